// File: rtl/serial_divisibility_by_n_fsm.sv
// serial_divisibility_by_n_fsm: running remainder mod DIVISOR of a serially received number,
// MSB-first or LSB-first per number, with valid qualifier, restart and saturating bit counter.
module serial_divisibility_by_n_fsm #(
   parameter int DIVISOR  = 5,
   parameter int MAX_BITS = 32,
   parameter int RW       = $clog2(DIVISOR),
   parameter int CW       = $clog2(MAX_BITS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic          new_bit,
   input  logic          start,
   input  logic          lsb_first,
   output logic          div_by_n,
   output logic [RW-1:0] remainder,
   output logic [CW-1:0] bit_count,
   output logic          count_sat
);
   typedef enum logic {mode_msb = 1'b0, mode_lsb = 1'b1} mode_t;

   localparam logic [RW:0]   n       = (RW + 1)'(DIVISOR);
   localparam logic [CW-1:0] max_cnt = CW'(MAX_BITS);
   localparam logic [RW-1:0] two_mod = RW'(DIVISOR == 2 ? 0 : 2);

   if (DIVISOR < 2 || DIVISOR > 255) begin : g_bad_divisor
      $error("DIVISOR must be in 2..255");
   end
   if (MAX_BITS < 1) begin : g_bad_max_bits
      $error("MAX_BITS must be at least 1");
   end

   // Operands are already below 2N, so one conditional subtract reduces them mod N.
   function automatic logic [RW-1:0] red(input logic [RW:0] t);
      return RW'(t >= n ? t - n : t);
   endfunction

   logic [RW-1:0] rem, rem_next, pow, pow_next;
   logic [CW-1:0] cnt, cnt_next;
   mode_t         mode, mode_next;
   logic [RW:0]   t_msb, t_lsb, u;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem  <= '0;
         pow  <= RW'(1);
         mode <= mode_msb;
         cnt  <= '0;
      end else begin
         rem  <= rem_next;
         pow  <= pow_next;
         mode <= mode_next;
         cnt  <= cnt_next;
      end
   end

   always_comb begin
      rem_next  = rem;
      pow_next  = pow;
      mode_next = mode;
      cnt_next  = cnt;
      t_msb     = {rem, new_bit};
      t_lsb     = {1'b0, rem} + (new_bit ? {1'b0, pow} : '0);
      u         = {pow, 1'b0};
      if (start) begin
         mode_next = mode_t'(lsb_first);
         rem_next  = in_valid ? RW'(new_bit) : '0;
         pow_next  = (in_valid && lsb_first) ? two_mod : RW'(1);
         cnt_next  = in_valid ? CW'(1) : '0;
      end else if (in_valid) begin
         rem_next = (mode == mode_lsb) ? red(t_lsb) : red(t_msb);
         pow_next = (mode == mode_lsb) ? red(u) : pow;
         cnt_next = (cnt == max_cnt) ? cnt : cnt + CW'(1);
      end
   end

   assign div_by_n  = (rem == '0);
   assign remainder = rem;
   assign bit_count = cnt;
   assign count_sat = (cnt == max_cnt);
endmodule
